d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 39 +++
 tb/tb_d_flip_flop.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
`timescale 1ns/1ps
// d_flip_flop: parameterizable positive-edge D flip-flop with asynchronous
// active-low reset.
//
// Ports:
//   clk : system clock; d is captured on the rising edge
//   rst : asynchronous active-low reset (0 = reset asserted)
//   d   : data to capture, WIDTH bits
//   q   : registered data, WIDTH bits, driven straight from the storage element
//
// Parameters:
//   WIDTH       : data width, 1..1024
//   RESET_VALUE : value held on q while rst is low; because the parameter is
//                 declared WIDTH bits wide, wider values are truncated and
//                 narrower ones are zero-extended.
module d_flip_flop #(
  parameter int unsigned        WIDTH       = 1,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Storage element: reset overrides at once, otherwise capture d every rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: tb/tb_d_flip_flop.sv
`timescale 1ns/1ps
// Bench for d_flip_flop: a 1-bit default instance and an 8-bit instance with
// reset value 8'hA5, checked against an event-driven model every cycle plus
// hand-computed literal expectations at fixed points.
module tb_d_flip_flop;

  logic       clk;
  logic       rst;
  logic       d;
  logic       q;
  logic       rst8;
  logic [7:0] d8;
  logic [7:0] q8;

  int n_checks = 0;
  int n_fail   = 0;

  d_flip_flop u_dut1 (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  d_flip_flop #(
    .WIDTH       (8),
    .RESET_VALUE (8'hA5)
  ) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .d   (d8),
    .q   (q8)
  );

  // Rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: q is the reset value whenever reset is low or was low at the last
  // edge; otherwise it is whatever d was at the last rising edge.
  logic       m_valid  = 1'b0;
  logic       m_q      = 1'b0;
  logic       m8_valid = 1'b0;
  logic [7:0] m8_q     = 8'h00;

  always @(negedge rst) begin
    m_q     = 1'b0;
    m_valid = 1'b1;
  end

  always @(posedge clk) begin
    if (m_valid) m_q = rst ? d : 1'b0;
  end

  always @(negedge rst8) begin
    m8_q     = 8'hA5;
    m8_valid = 1'b1;
  end

  always @(posedge clk) begin
    if (m8_valid) m8_q = rst8 ? d8 : 8'hA5;
  end

  // Compare process: once per cycle, shortly after the rising edge
  always @(posedge clk) begin
    #1;
    if (m_valid)  chk("q_vs_model",  8'(q), 8'(m_q));
    if (m8_valid) chk("q8_vs_model", q8, m8_q);
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [3:0] pat;
  logic       prev;

  initial begin
    rst  = 1'b1;
    d    = 1'b0;
    rst8 = 1'b1;
    d8   = 8'h00;
    pat  = 4'b1001;          // d sequence 1,0,0,1 read from bit 3 down

    // Initial reset pulse, then load q=1 on the edge at t=15
    #2  rst = 1'b0;          // t=2
    #1  chk("init_reset", 8'(q), 8'h00);
    #4  rst = 1'b1;          // t=7
    d = 1'b1;
    #9  chk("capture_t15", 8'(q), 8'h01);     // t=16

    // Async reset assertion between edges
    #1  rst = 1'b0;          // t=17
    #1  chk("async_reset_t18", 8'(q), 8'h00); // t=18, no edge since 15
    #8  chk("reset_hold_t26", 8'(q), 8'h00);  // t=26, edge at 25 ignored

    // Release mid-cycle with d=1
    #1  rst = 1'b1;          // t=27
    #3  chk("release_hold_t30", 8'(q), 8'h00);
    #6  chk("release_cap_t36", 8'(q), 8'h01); // t=36

    // Capture and hold: d changes mid-cycle, q follows one edge later
    prev = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      #2 d = pat[i];                          // edge+3
      #1 chk("midcycle_no_effect", 8'(q), 8'(prev));
      #2 chk("negedge_no_effect", 8'(q), 8'(prev));
      @(posedge clk);
      #1 chk("follow_seq", 8'(q), 8'(pat[i]));
      prev = pat[i];
    end

    // Random data, checked by the compare process each cycle
    for (int i = 0; i < 10; i++) begin
      #2 d = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end

    // Reset asserted exactly on a rising edge with d=1
    #2 d = 1'b1;
    @(posedge clk);
    #1 chk("preload_one", 8'(q), 8'h01);
    @(posedge clk);
    rst = 1'b0;
    #1 chk("reset_on_edge", 8'(q), 8'h00);
    @(posedge clk);
    #1 chk("reset_on_edge_hold", 8'(q), 8'h00);

    // Release in the timestep of a rising edge: that edge sees rst low
    @(posedge clk);
    #0.001 rst = 1'b1;
    #1 chk("release_on_edge_nocap", 8'(q), 8'h00);
    @(posedge clk);
    #1 chk("release_on_edge_next", 8'(q), 8'h01);

    // 8-bit instance with reset value A5
    #1 rst8 = 1'b0;                           // edge+2
    #1 chk("w8_reset", q8, 8'hA5);
    d8 = 8'h3C;
    @(posedge clk);
    #1 chk("w8_reset_ignores_d", q8, 8'hA5);
    #2 rst8 = 1'b1;                           // edge+3
    @(posedge clk);
    #1 chk("w8_first", q8, 8'h3C);
    #2 d8 = 8'hFF;
    @(posedge clk);
    #1 chk("w8_second", q8, 8'hFF);
    #2 rst8 = 1'b0;                           // mid-cycle assertion
    #1 chk("w8_async_mid", q8, 8'hA5);
    #2 rst8 = 1'b1;
    @(posedge clk);
    #1 chk("w8_resume", q8, 8'hFF);

    @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
